stump_mem_responder: RTL and testbench

Memory-side responder for the Stump processor's data/instruction memory interface: it answers requests issued by the processor's memory initiator using a four-phase REQ/ACK handshake, holds a small word-addressed RAM, and inserts a fixed, parameterised number of wait states so the processor's stall logic can be exercised. It sits between the Stump datapath's address/data registers and the bench or FPGA top level, replacing a zero-latency behavioural memory.

---
 rtl/stump_mem_pkg.sv | 23 ++
 rtl/stump_mem_array.sv | 24 ++
 rtl/stump_mem_responder.sv | 127 ++++++++++++
 tb/tb_stump_mem_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stump_mem_pkg.sv
// Shared definitions for the Stump memory responder, its RAM and any
// initiator or bench that talks to it.
package stump_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W               = 4;
    localparam int DATA_W              = 16;
    localparam int ADDR_W              = 16;
    localparam int DEFAULT_DEPTH_LOG2  = 8;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    // Any set bit above the RAM's index range makes the access out of range.
    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr,
                                               input int depth_log2);
        return (addr >> depth_log2) != '0;
    endfunction

endpackage

// File: rtl/stump_mem_array.sv
// Single-port word RAM: synchronous write, registered read, no reset so it
// maps onto block RAM.
module stump_mem_array
    import stump_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic                  we,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(2**DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/stump_mem_responder.sv
// Four-phase REQ/ACK memory responder with a fixed number of wait states,
// used to exercise the Stump processor's memory stall path.
module stump_mem_responder
    import stump_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DIN,
    output logic              ACK,
    output logic [DATA_W-1:0] DOUT,
    output logic              ERR,
    output logic              BUSY
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              wen_reg;
    logic [DATA_W-1:0] din_reg;
    logic [DATA_W-1:0] dout_reg;
    logic              err_reg;

    logic              latch_en;
    logic              resp_entry;
    logic              leave_resp;
    logic              addr_oor;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        latch_en   = 1'b0;
        resp_entry = 1'b0;
        leave_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (REQ) begin
                    state_next = WAIT;
                    cnt_next   = WAIT_INIT;
                    latch_en   = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                    resp_entry = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RESP: begin
                if (!REQ) begin
                    state_next = IDLE;
                    leave_resp = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign addr_oor = addr_out_of_range(addr_reg, DEPTH_LOG2);

    // In IDLE the RAM is addressed straight from the port so that read data
    // for the latched address is ready even with zero wait states.
    assign ram_addr = (state_reg == IDLE) ? ADDR[DEPTH_LOG2-1:0]
                                          : addr_reg[DEPTH_LOG2-1:0];
    assign ram_we   = resp_entry && wen_reg && !addr_oor;

    stump_mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk   (CLK),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (din_reg),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wen_reg   <= 1'b0;
            din_reg   <= '0;
            dout_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (latch_en) begin
                addr_reg <= ADDR;
                wen_reg  <= WEN;
                din_reg  <= DIN;
            end
            if (resp_entry) begin
                err_reg <= addr_oor;
                if (addr_oor) begin
                    dout_reg <= '0;
                end else if (wen_reg) begin
                    dout_reg <= din_reg;
                end else begin
                    dout_reg <= ram_rdata;
                end
            end
            if (leave_resp) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign ACK  = (state_reg == RESP);
    assign BUSY = (state_reg != IDLE);
    assign DOUT = dout_reg;
    assign ERR  = err_reg;

endmodule

// File: tb/tb_stump_mem_responder.sv
// Scoreboard bench: one responder with two wait states, one with none.
module tb_stump_mem_responder;

    logic        clk;
    logic        rst;
    logic        req, wen;
    logic [15:0] addr, din;
    logic        ack, err, busy;
    logic [15:0] dout;
    logic        req0, wen0;
    logic [15:0] addr0, din0;
    logic        ack0, err0, busy0;
    logic [15:0] dout0;

    typedef struct {
        logic [15:0] dout;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model2 [int];
    logic [15:0] model0 [int];
    int          n_checks;
    int          n_fail;

    stump_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .WEN(wen), .ADDR(addr), .DIN(din),
        .ACK(ack), .DOUT(dout), .ERR(err), .BUSY(busy)
    );

    stump_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
        .CLK(clk), .RST(rst), .REQ(req0), .WEN(wen0), .ADDR(addr0), .DIN(din0),
        .ACK(ack0), .DOUT(dout0), .ERR(err0), .BUSY(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_ack(input bit sel);
        return sel ? ack0 : ack;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? busy0 : busy;
    endfunction
    function automatic logic get_err(input bit sel);
        return sel ? err0 : err;
    endfunction
    function automatic logic [15:0] get_dout(input bit sel);
        return sel ? dout0 : dout;
    endfunction

    task automatic drive_req(input bit sel, input logic v);
        if (sel) req0 = v;
        else     req  = v;
    endtask

    task automatic drive_cmd(input bit sel, input logic w, input logic [15:0] a,
                             input logic [15:0] d);
        if (sel) begin
            wen0 = w; addr0 = a; din0 = d;
        end else begin
            wen = w; addr = a; din = d;
        end
    endtask

    // One full access: pushes the expected response, waits for ACK, then
    // checks latency, data, ERR, the hold phase and the BUSY duration.
    task automatic access(input bit sel, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input int hold,
                          input bit drop_in_wait, input string tag);
        exp_t        e;
        exp_t        got;
        int          c;
        int          busy_n;
        int          wc;
        logic [15:0] held;
        wc = sel ? 0 : 2;
        e.err = (a[15:8] != 8'h00);
        if (e.err) begin
            e.dout = 16'h0000;
        end else if (w) begin
            e.dout = d;
            if (sel) model0[int'(a)] = d;
            else     model2[int'(a)] = d;
        end else begin
            e.dout = sel ? model0[int'(a)] : model2[int'(a)];
        end
        sb.push_back(e);

        @(negedge clk);
        drive_cmd(sel, w, a, d);
        drive_req(sel, 1'b1);
        c = 0;
        busy_n = 0;
        while (c < 40) begin
            @(negedge clk);
            c++;
            if (get_busy(sel)) busy_n++;
            if (drop_in_wait && c == 1) drive_req(sel, 1'b0);
            if (get_ack(sel)) break;
        end
        n_checks++;
        if (get_ack(sel) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ack_timeout: ack=%b after %0d cycles, required 1", tag, get_ack(sel), c);
            void'(sb.pop_front());
            drive_req(sel, 1'b0);
            @(negedge clk);
            return;
        end
        n_checks++;
        if ((c - 1) !== (wc + 1)) begin
            n_fail++;
            $display("FAIL %s latency: ack after edge n+%0d, required n+%0d", tag, c - 1, wc + 1);
        end
        got = sb.pop_front();
        n_checks++;
        if (get_dout(sel) !== got.dout) begin
            n_fail++;
            $display("FAIL %s dout: got %h, required %h", tag, get_dout(sel), got.dout);
        end
        n_checks++;
        if (get_err(sel) !== got.err) begin
            n_fail++;
            $display("FAIL %s err: got %b, required %b", tag, get_err(sel), got.err);
        end
        held = get_dout(sel);
        if (!drop_in_wait) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (get_busy(sel)) busy_n++;
                n_checks++;
                if (get_ack(sel) !== 1'b1 || get_dout(sel) !== held) begin
                    n_fail++;
                    $display("FAIL %s hold[%0d]: ack=%b dout=%h, required ack=1 dout=%h",
                             tag, h, get_ack(sel), get_dout(sel), held);
                end
            end
            drive_req(sel, 1'b0);
        end
        @(negedge clk);
        if (get_busy(sel)) busy_n++;
        n_checks++;
        if (get_ack(sel) !== 1'b0 || get_err(sel) !== 1'b0 || get_dout(sel) !== held) begin
            n_fail++;
            $display("FAIL %s release: ack=%b err=%b dout=%h, required ack=0 err=0 dout=%h",
                     tag, get_ack(sel), get_err(sel), get_dout(sel), held);
        end
        n_checks++;
        if (busy_n !== wc + 2 + (drop_in_wait ? 0 : hold)) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d, required %0d", tag, busy_n,
                     wc + 2 + (drop_in_wait ? 0 : hold));
        end
        $display("txn %s: dut=%0d wen=%0b addr=%h din=%h -> dout=%h err=%b lat=%0d busy=%0d",
                 tag, sel ? 0 : 2, w, a, d, held, got.err, c - 1, busy_n);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || dout !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_w2: ack=%b err=%b busy=%b dout=%h, required 0 0 0 0000", ack, err, busy, dout);
        end
        n_checks++;
        if (ack0 !== 1'b0 || err0 !== 1'b0 || busy0 !== 1'b0 || dout0 !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_w0: ack=%b err=%b busy=%b dout=%h, required 0 0 0 0000", ack0, err0, busy0, dout0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_write_read();
        access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 0, 1'b0, "wr_0010");
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, "rd_0010");
        access(1'b0, 1'b1, 16'h00FF, 16'h1357, 0, 1'b0, "wr_00ff");
        access(1'b0, 1'b0, 16'h00FF, 16'h0000, 0, 1'b0, "rd_00ff");
    endtask

    task automatic test_zero_wait();
        access(1'b1, 1'b1, 16'h0042, 16'hC0DE, 0, 1'b0, "w0_wr_0042");
        access(1'b1, 1'b0, 16'h0042, 16'h0000, 0, 1'b0, "w0_rd_0042");
    endtask

    task automatic test_out_of_range();
        access(1'b0, 1'b1, 16'h0000, 16'h7777, 0, 1'b0, "wr_0000");
        access(1'b0, 1'b1, 16'h0100, 16'h1234, 0, 1'b0, "oor_wr_0100");
        access(1'b0, 1'b0, 16'h8000, 16'h0000, 0, 1'b0, "oor_rd_8000");
        access(1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, "rd_0000");
    endtask

    task automatic test_hold();
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 5, 1'b0, "hold_rd_0010");
        access(1'b1, 1'b0, 16'h0042, 16'h0000, 3, 1'b0, "w0_hold_rd_0042");
    endtask

    task automatic test_violation();
        access(1'b0, 1'b1, 16'h0020, 16'h5A5A, 0, 1'b1, "viol_wr_0020");
        access(1'b0, 1'b0, 16'h0020, 16'h0000, 0, 1'b0, "rd_0020");
    endtask

    task automatic test_reset_mid();
        access(1'b0, 1'b1, 16'h0030, 16'h0001, 0, 1'b0, "wr_0030");
        @(negedge clk);
        drive_cmd(1'b0, 1'b1, 16'h0030, 16'hFFFF);
        drive_req(1'b0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: busy=%b, required 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (ack !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || dout !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_mid: ack=%b busy=%b err=%b dout=%h, required 0 0 0 0000", ack, busy, err, dout);
        end
        @(negedge clk);
        drive_req(1'b0, 1'b0);
        rst = 1'b0;
        $display("txn rst_mid: write of ffff to 0030 aborted in WAIT");
        access(1'b0, 1'b0, 16'h0030, 16'h0000, 0, 1'b0, "rd_0030_after_rst");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 1'b1, 16'h0080 + 16'(i), 16'($urandom_range(0, 65535)), 0, 1'b0, "b2b_wr");
        end
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 1'b0, 16'h0080 + 16'(i), 16'h0000, 0, 1'b0, "b2b_rd");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        req  = 1'b0; wen  = 1'b0; addr  = 16'h0; din  = 16'h0;
        req0 = 1'b0; wen0 = 1'b0; addr0 = 16'h0; din0 = 16'h0;
        test_reset();
        test_write_read();
        test_zero_wait();
        test_out_of_range();
        test_hold();
        test_violation();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
